// File: rtl/symbol_scrambler.sv
// Frame-aware I/Q symbol scrambler: headers pass through unchanged, payload symbols are rotated by the randomizer value.
// Optional build macro SCRAMBLER_LENGTH_CHECK_EN: a start-of-frame seen mid-frame flags o_len_err and restarts the frame.
module symbol_scrambler #(
  parameter int W       = 8,
  parameter int HDR_LEN = 90,
  parameter int PAY_LEN = 8100
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_sym_i,
  input  logic [W-1:0] i_sym_q,
  input  logic         i_sof,
  input  logic [1:0]   i_rnd,
  output logic         o_rnd_reset,
  output logic         o_rnd_en,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_sym_i,
  output logic [W-1:0] o_sym_q,
  output logic         o_sof,
  output logic         o_eof,
  output logic         o_len_err
);

  localparam int CNT_MAX = (HDR_LEN > PAY_LEN) ? HDR_LEN : PAY_LEN;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HDR_LAST = CW'(HDR_LEN - 1);
  localparam logic [CW-1:0] PAY_LAST = CW'(PAY_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [W-1:0]  MIN_VAL  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  ONE_VAL  = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] count_reg;
  logic          valid_reg;
  logic [W-1:0]  sym_i_reg;
  logic [W-1:0]  sym_q_reg;
  logic          sof_reg;
  logic          eof_reg;
  logic          rnd_reset_reg;
  logic          start_seen_reg;
  logic          prime_reg;

  logic          accept;
  logic          restart_cond;
  logic          frame_start;
  logic          payload_acc;
  logic [W-1:0]  rot_i_next;
  logic [W-1:0]  rot_q_next;

  // Negating the most negative value would overflow, so it clamps to the most positive.
  function automatic logic [W-1:0] sat_neg(input logic [W-1:0] x);
    if (x == MIN_VAL) begin
      return ~MIN_VAL;
    end
    return ~x + ONE_VAL;
  endfunction

  assign o_ready = !valid_reg || i_ready;
  assign accept  = i_valid && o_ready;

`ifdef SCRAMBLER_LENGTH_CHECK_EN
  assign restart_cond = i_sof && (state_reg != ST_IDLE);
`else
  assign restart_cond = 1'b0;
`endif

  assign frame_start = accept && i_sof && ((state_reg == ST_IDLE) || restart_cond);
  assign payload_acc = accept && (state_reg == ST_PAY) && !restart_cond;

  // One randomizer advance per payload symbol, plus the priming pulse after a frame start.
  assign o_rnd_en = prime_reg || payload_acc;

  always_comb begin
    rot_i_next = i_sym_i;
    rot_q_next = i_sym_q;
    case (i_rnd)
      2'd1: begin
        rot_i_next = sat_neg(i_sym_q);
        rot_q_next = i_sym_i;
      end
      2'd2: begin
        rot_i_next = sat_neg(i_sym_i);
        rot_q_next = sat_neg(i_sym_q);
      end
      2'd3: begin
        rot_i_next = i_sym_q;
        rot_q_next = sat_neg(i_sym_i);
      end
      default: begin
        rot_i_next = i_sym_i;
        rot_q_next = i_sym_q;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg      <= ST_IDLE;
      count_reg      <= '0;
      valid_reg      <= 1'b0;
      sym_i_reg      <= '0;
      sym_q_reg      <= '0;
      sof_reg        <= 1'b0;
      eof_reg        <= 1'b0;
      rnd_reset_reg  <= 1'b1;
      start_seen_reg <= 1'b0;
      prime_reg      <= 1'b0;
    end else begin
      rnd_reset_reg  <= frame_start;
      start_seen_reg <= frame_start;
      prime_reg      <= start_seen_reg;
      // The output register only moves when it is empty or being drained.
      if (o_ready) begin
        valid_reg <= 1'b0;
        sof_reg   <= 1'b0;
        eof_reg   <= 1'b0;
        if (accept) begin
          if (frame_start) begin
            valid_reg <= 1'b1;
            sym_i_reg <= i_sym_i;
            sym_q_reg <= i_sym_q;
            sof_reg   <= 1'b1;
            state_reg <= ST_HDR;
            count_reg <= CNT_ONE;
          end else begin
            case (state_reg)
              ST_HDR: begin
                valid_reg <= 1'b1;
                sym_i_reg <= i_sym_i;
                sym_q_reg <= i_sym_q;
                if (count_reg == HDR_LAST) begin
                  state_reg <= ST_PAY;
                  count_reg <= '0;
                end else begin
                  count_reg <= count_reg + CNT_ONE;
                end
              end
              ST_PAY: begin
                valid_reg <= 1'b1;
                sym_i_reg <= rot_i_next;
                sym_q_reg <= rot_q_next;
                if (count_reg == PAY_LAST) begin
                  eof_reg   <= 1'b1;
                  state_reg <= ST_IDLE;
                  count_reg <= '0;
                end else begin
                  count_reg <= count_reg + CNT_ONE;
                end
              end
              default: begin
                state_reg <= ST_IDLE;
                count_reg <= '0;
              end
            endcase
          end
        end
      end
    end
  end

`ifdef SCRAMBLER_LENGTH_CHECK_EN
  logic len_err_reg;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      len_err_reg <= 1'b0;
    end else if (accept && restart_cond) begin
      len_err_reg <= 1'b1;
    end
  end

  assign o_len_err = len_err_reg;
`else
  assign o_len_err = 1'b0;
`endif

  assign o_valid     = valid_reg;
  assign o_sym_i     = sym_i_reg;
  assign o_sym_q     = sym_q_reg;
  assign o_sof       = sof_reg;
  assign o_eof       = eof_reg;
  assign o_rnd_reset = rnd_reset_reg;

endmodule

// File: tb/tb_symbol_scrambler.sv
// Directed bench for symbol_scrambler (W=8, HDR_LEN=4, PAY_LEN=6); expectations follow SCRAMBLER_LENGTH_CHECK_EN.
module tb_symbol_scrambler;

`ifdef SCRAMBLER_LENGTH_CHECK_EN
  localparam logic RESTART = 1'b1;
`else
  localparam logic RESTART = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_sym_i;
  logic [7:0] i_sym_q;
  logic       i_sof;
  logic [1:0] i_rnd;
  logic       o_rnd_reset;
  logic       o_rnd_en;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_sym_i;
  logic [7:0] o_sym_q;
  logic       o_sof;
  logic       o_eof;
  logic       o_len_err;

  always #5 i_clk = ~i_clk;

  symbol_scrambler #(.W(8), .HDR_LEN(4), .PAY_LEN(6)) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_sym_i    (i_sym_i),
    .i_sym_q    (i_sym_q),
    .i_sof      (i_sof),
    .i_rnd      (i_rnd),
    .o_rnd_reset(o_rnd_reset),
    .o_rnd_en   (o_rnd_en),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_sym_i    (o_sym_i),
    .o_sym_q    (o_sym_q),
    .o_sof      (o_sof),
    .o_eof      (o_eof),
    .o_len_err  (o_len_err)
  );

  int checks = 0;
  int errors = 0;

  // Monitor state, written only by the negedge sampler.
  int          cyc = 0;
  int          out_n = 0;
  int          en_total = 0;
  int          sof_cyc = 0;
  logic [17:0] out_log [0:255];
  logic        rst_log [0:4095];
  logic        en_log  [0:4095];

  // Expected outputs, written only by the stimulus process.
  logic [17:0] exp_log [0:255];
  int          exp_n = 0;
  int          rd_idx = 0;

  always @(negedge i_clk) begin
    if (cyc < 4096) begin
      rst_log[cyc] = o_rnd_reset;
      en_log[cyc]  = o_rnd_en;
    end
    if (o_rnd_en) en_total++;
    if (i_valid && o_ready && i_sof) sof_cyc = cyc;
    if (o_valid && i_ready && out_n < 256) begin
      out_log[out_n] = {o_sym_i, o_sym_q, o_sof, o_eof};
      out_n++;
    end
    cyc++;
  end

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic send(input int si, input int sq, input logic sof, input logic [1:0] rnd,
                      input logic fwd, input int ei, input int eq, input logic esof, input logic eeof);
    int waited;
    i_sym_i = 8'(si);
    i_sym_q = 8'(sq);
    i_sof   = sof;
    i_rnd   = rnd;
    i_valid = 1'b1;
    if (fwd) begin
      exp_log[exp_n] = {8'(ei), 8'(eq), esof, eeof};
      exp_n++;
    end
    $display("tx in=(%0d,%0d) sof=%0b rnd=%0d fwd=%0b", si, sq, sof, rnd, fwd);
    waited = 0;
    @(negedge i_clk);
    while (!o_ready && waited < 50) begin
      @(negedge i_clk);
      waited++;
    end
    if (!o_ready) check_value("send_ready", 32'(o_ready), 32'd1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  task automatic verify_outputs(input string tag);
    repeat (3) @(posedge i_clk);
    #1;
    check_value({tag, "_count"}, 32'(out_n), 32'(exp_n));
    for (int k = rd_idx; k < exp_n; k++) begin
      $display("rx %s #%0d got=%05h want=%05h", tag, k - rd_idx, out_log[k], exp_log[k]);
      check_value($sformatf("%s_sym%0d", tag, k - rd_idx), 32'(out_log[k]), 32'(exp_log[k]));
    end
    exp_n  = out_n;
    rd_idx = out_n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int en0;
    int s_mid;

    i_reset_n = 1'b0;
    i_valid   = 1'b0;
    i_ready   = 1'b1;
    i_sym_i   = '0;
    i_sym_q   = '0;
    i_sof     = 1'b0;
    i_rnd     = '0;

    // Reset values while held in reset
    repeat (3) @(posedge i_clk);
    #1;
    check_value("rst_valid", 32'(o_valid), 32'd0);
    check_value("rst_rnd_reset", 32'(o_rnd_reset), 32'd1);
    check_value("rst_rnd_en", 32'(o_rnd_en), 32'd0);
    check_value("rst_len_err", 32'(o_len_err), 32'd0);
    check_value("rst_outs", 32'({o_sym_i, o_sym_q, o_sof, o_eof}), 32'd0);

    i_reset_n = 1'b1;
    @(negedge i_clk);
    check_value("rel_rnd_reset_first", 32'(o_rnd_reset), 32'd1);
    @(negedge i_clk);
    check_value("rel_rnd_reset_drop", 32'(o_rnd_reset), 32'd0);
    check_value("rel_valid", 32'(o_valid), 32'd0);
    check_value("rel_len_err", 32'(o_len_err), 32'd0);
    @(posedge i_clk);
    #1;

    // Symbols without sof are swallowed in IDLE at full rate
    c0 = cyc;
    for (int k = 0; k < 3; k++) send(k + 1, k + 2, 1'b0, 2'd0, 1'b0, 0, 0, 1'b0, 1'b0);
    check_value("idle_cycles", 32'(cyc - c0), 32'd3);
    repeat (2) @(posedge i_clk);
    #1;
    check_value("idle_valid", 32'(o_valid), 32'd0);
    check_value("idle_no_out", 32'(out_n), 32'd0);

    // Frame A: rotation by 1, header ignores i_rnd
    en0 = en_total;
    send(10, 20, 1'b1, 2'd1, 1'b1, 10, 20, 1'b1, 1'b0);
    c0 = sof_cyc;
    for (int k = 0; k < 3; k++) send(10, 20, 1'b0, 2'd1, 1'b1, 10, 20, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) send(10, 20, 1'b0, 2'd1, 1'b1, -20, 10, 1'b0, k == 5);
    verify_outputs("frameA");
    check_value("frameA_rnd_en_total", 32'(en_total - en0), 32'd7);
    check_value("frameA_rnd_reset_t1", 32'(rst_log[c0 + 1]), 32'd1);
    check_value("frameA_rnd_reset_t2", 32'(rst_log[c0 + 2]), 32'd0);
    check_value("frameA_rnd_en_t1", 32'(en_log[c0 + 1]), 32'd0);
    check_value("frameA_rnd_en_t2", 32'(en_log[c0 + 2]), 32'd1);

    // Frame B: saturating negation and a 3-cycle downstream stall
    en0 = en_total;
    send(1, 2, 1'b1, 2'd0, 1'b1, 1, 2, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) send(1, 2, 1'b0, 2'd0, 1'b1, 1, 2, 1'b0, 1'b0);
    send(-128, 0, 1'b0, 2'd2, 1'b1, 127, 0, 1'b0, 1'b0);
    send(0, -128, 1'b0, 2'd3, 1'b1, -128, 0, 1'b0, 1'b0);
    i_sym_i = 8'd5;
    i_sym_q = 8'hF9;
    i_rnd   = 2'd0;
    i_valid = 1'b1;
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check_value($sformatf("stall%0d_ready", k), 32'(o_ready), 32'd0);
      check_value($sformatf("stall%0d_rnd_en", k), 32'(o_rnd_en), 32'd0);
      check_value($sformatf("stall%0d_valid", k), 32'(o_valid), 32'd1);
      check_value($sformatf("stall%0d_hold", k), 32'({o_sym_i, o_sym_q, o_sof, o_eof}), 32'h20000);
    end
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    send(5, -7, 1'b0, 2'd0, 1'b1, 5, -7, 1'b0, 1'b0);
    send(5, -7, 1'b0, 2'd1, 1'b1, 7, 5, 1'b0, 1'b0);
    send(-128, -128, 1'b0, 2'd2, 1'b1, 127, 127, 1'b0, 1'b0);
    send(3, 4, 1'b0, 2'd3, 1'b1, 4, -3, 1'b0, 1'b1);
    verify_outputs("frameB");
    check_value("frameB_rnd_en_total", 32'(en_total - en0), 32'd7);

    // Frame C: sof arrives on the third payload symbol
    en0 = en_total;
    send(10, 20, 1'b1, 2'd0, 1'b1, 10, 20, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) send(10, 20, 1'b0, 2'd0, 1'b1, 10, 20, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) send(10, 20, 1'b0, 2'd1, 1'b1, -20, 10, 1'b0, 1'b0);
`ifdef SCRAMBLER_LENGTH_CHECK_EN
    send(30, 40, 1'b1, 2'd1, 1'b1, 30, 40, 1'b1, 1'b0);
    s_mid = sof_cyc;
    for (int k = 0; k < 3; k++) send(30, 40, 1'b0, 2'd0, 1'b1, 30, 40, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) send(30, 40, 1'b0, 2'd0, 1'b1, 30, 40, 1'b0, k == 5);
    verify_outputs("frameC");
    check_value("frameC_rnd_en_total", 32'(en_total - en0), 32'd10);
`else
    send(30, 40, 1'b1, 2'd1, 1'b1, -40, 30, 1'b0, 1'b0);
    s_mid = sof_cyc;
    for (int k = 0; k < 3; k++) send(30, 40, 1'b0, 2'd0, 1'b1, 30, 40, 1'b0, k == 2);
    verify_outputs("frameC");
    check_value("frameC_rnd_en_total", 32'(en_total - en0), 32'd7);
`endif
    check_value("frameC_len_err", 32'(o_len_err), 32'(RESTART));
    check_value("frameC_rnd_reset_t1", 32'(rst_log[s_mid + 1]), 32'(RESTART));
    check_value("frameC_rnd_en_t1", 32'(en_log[s_mid + 1]), 32'(!RESTART));

    // Reset mid-header abandons the frame; later non-sof symbols are dropped
    send(1, 1, 1'b1, 2'd0, 1'b1, 1, 1, 1'b1, 1'b0);
    send(2, 2, 1'b0, 2'd0, 1'b0, 0, 0, 1'b0, 1'b0);
    i_reset_n = 1'b0;
    @(negedge i_clk);
    check_value("midrst_valid", 32'(o_valid), 32'd0);
    check_value("midrst_len_err", 32'(o_len_err), 32'd0);
    check_value("midrst_rnd_reset", 32'(o_rnd_reset), 32'd1);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    send(7, 7, 1'b0, 2'd1, 1'b0, 0, 0, 1'b0, 1'b0);
    send(8, 8, 1'b0, 2'd1, 1'b0, 0, 0, 1'b0, 1'b0);
    verify_outputs("midrst");
    check_value("midrst_idle_valid", 32'(o_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/symbol_scrambler.md
SYMBOL_SCRAMBLER -- requirements
Module: symbol_scrambler

Interface
REQ-001 Parameter W, default 8: signed I/Q sample width, two's complement.
REQ-002 Parameter HDR_LEN, default 90: header symbols per frame, passed unscrambled; SHALL be >= 3.
REQ-003 Parameter PAY_LEN, default 8100: payload symbols per frame, scrambled; SHALL be >= 1.
REQ-004 i_clk  in  1  sole clock; all state on rising edge.
REQ-005 i_reset_n  in  1  reset, asynchronous, active-low.
REQ-006 i_valid  in  1  upstream symbol valid.
REQ-007 o_ready  out  1  upstream may transfer.
REQ-008 i_sym_i, i_sym_q  in  W each  input symbol I/Q.
REQ-009 i_sof  in  1  input symbol is first header symbol of a frame.
REQ-010 i_rnd  in  2  current 2-bit randomizer value Rn.
REQ-011 o_rnd_reset  out  1  synchronous reset request to randomizer.
REQ-012 o_rnd_en  out  1  advance request to randomizer.
REQ-013 o_valid  out  1  output symbol valid.
REQ-014 i_ready  in  1  downstream accepts.
REQ-015 o_sym_i, o_sym_q  out  W each  output symbol I/Q.
REQ-016 o_sof, o_eof  out  1 each  first header / last payload symbol marker.
REQ-017 o_len_err  out  1  sticky frame-length error flag (see REQ-033).

Function
REQ-018 Accept = i_valid & o_ready; o_ready = !o_valid | i_ready (single output register, latency 1 cycle from accept to o_valid).
REQ-019 o_valid, o_sym_*, o_sof, o_eof SHALL hold unchanged while o_valid & !i_ready.
REQ-020 States IDLE, HDR, PAY; counter counts accepted symbols within current state.
REQ-021 IDLE: accepted symbols without i_sof discarded (not forwarded); accepted i_sof symbol -> forwarded with o_sof=1, count=1, go HDR (or PAY if HDR_LEN reached, not reachable since HDR_LEN >= 3).
REQ-022 HDR: symbols forwarded unrotated; after HDR_LEN-th header symbol accepted -> PAY, count=0.
REQ-023 PAY: symbols forwarded rotated by i_rnd sampled in accept cycle: Rn=0 (I,Q); 1 (-Q,I); 2 (-I,-Q); 3 (Q,-I).
REQ-024 Negation SHALL saturate: -(-2^(W-1)) = 2^(W-1)-1; no other width change.
REQ-025 PAY_LEN-th payload symbol forwarded with o_eof=1 -> IDLE.
REQ-026 Accept of any i_sof symbol that starts a frame at cycle t -> o_rnd_reset=1 exactly at t+1, o_rnd_en=1 exactly at t+2 (prime), both registered single-cycle pulses.
REQ-027 In PAY, o_rnd_en = accept (combinational), one advance per payload symbol; o_rnd_en=0 otherwise except REQ-026 prime.
REQ-028 Per frame exactly 1+PAY_LEN o_rnd_en pulses; none while stalled.
REQ-029 i_rnd ignored outside PAY.

Reset
REQ-030 While i_reset_n=0: state IDLE, count 0, o_valid=0, o_sym_i=o_sym_q=0, o_sof=o_eof=0, o_rnd_en=0, o_len_err=0, o_rnd_reset=1.
REQ-031 o_rnd_reset SHALL drop to 0 on first clock edge after reset release unless REQ-026 applies.
REQ-032 Reset mid-frame SHALL abandon frame; no partial-frame resume.

Configuration
REQ-033 Macro SCRAMBLER_LENGTH_CHECK_EN defined: i_sof accepted in HDR or PAY sets o_len_err (sticky until reset) and restarts frame at that symbol per REQ-021/REQ-026; the interrupted frame emits no o_eof.
REQ-034 Macro undefined: i_sof in HDR/PAY ignored (symbol treated as ordinary), o_len_err tied 0.

Verification (W=8, HDR_LEN=4, PAY_LEN=6)
REQ-035 Reset release -> o_valid=0, o_rnd_reset=1 for first cycle then 0, o_len_err=0.
REQ-036 Frame of (10,20) with sof, i_rnd=1, i_ready=1 -> 4 outputs (10,20) first with o_sof, then 6 outputs (-20,10) last with o_eof; o_rnd_reset at t+1, o_rnd_en at t+2, 7 o_rnd_en total.
REQ-037 Payload (-128,0), i_rnd=2 -> (127,0); i_rnd=3 on (0,-128) -> (-128,0).
REQ-038 i_ready=0 for 3 cycles mid-payload -> outputs held, o_ready=0, o_rnd_en=0, no symbol lost or duplicated.
REQ-039 i_sof on 3rd payload symbol -> macro defined: o_len_err=1, that symbol output unrotated with o_sof, new o_rnd_reset/o_rnd_en prime; undefined: rotated as payload, o_len_err=0.
REQ-040 Symbols without sof in IDLE -> o_ready=1, o_valid stays 0.
